// File: rtl/romulus_pkg.sv
// Shared encodings and helpers for the Romulus TBC control sequencer.
// The rc next-state function is shared by the sequencer and any unrolled datapath.
package romulus_pkg;

    localparam logic [2:0] CMD_INIT    = 3'd0;
    localparam logic [2:0] CMD_LDKEY   = 3'd1;
    localparam logic [2:0] CMD_LDTWEAK = 3'd2;
    localparam logic [2:0] CMD_ABSORB  = 3'd3;
    localparam logic [2:0] CMD_TBC     = 3'd4;
    localparam logic [2:0] CMD_INCCNT  = 3'd5;

    localparam logic [5:0] RC_INIT = 6'h01;
    localparam logic [3:0] C2      = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_LDKEY   = 3'd2,
        S_LDTW    = 3'd3,
        S_ABSORB  = 3'd4,
        S_ROUND   = 3'd5,
        S_CORRECT = 3'd6,
        S_INCCNT  = 3'd7
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [5:0]  rc;
        logic [5:0]  round_cnt;
        logic [7:0]  beat_cnt;
    } dbg_t;

    // SKINNY 6-bit round-constant LFSR step.
    function automatic logic [5:0] rc_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/romulus_rc_lfsr.sv
// SKINNY round-constant generator: reload on load, advance on step.
// constant packs C2 with the split rc field as the datapath expects it.
module romulus_rc_lfsr
    import romulus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [5:0]  rc,
    output logic [11:0] constant
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            rc <= RC_INIT;
        end else if (step) begin
            rc <= rc_next(rc);
        end
    end

    assign constant = {C2, 2'b00, rc[5:4], rc[3:0]};

endmodule

// File: rtl/romulus_tbc_sequencer.sv
// Romulus control sequencer: turns single commands and pdi/sdi/pdo handshakes
// into per-cycle datapath enables, resets and selects.
module romulus_tbc_sequencer
    import romulus_pkg::*;
#(
    parameter int buswidth      = 128,
    parameter int constantwidth = 12,
    parameter int NROUNDS       = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd,
    input  logic [7:0]                cmd_domain,
    input  logic                      cmd_decrypt,
    input  logic                      sdi_valid,
    output logic                      sdi_ready,
    input  logic                      pdi_valid,
    output logic                      pdi_ready,
    output logic                      pdo_valid,
    input  logic                      pdo_ready,
    output logic                      done,
    output logic [constantwidth-1:0]  constant,
    output logic [buswidth/8-1:0]     decrypt,
    output logic [7:0]                domain,
    output logic                      srst,
    output logic                      senc,
    output logic                      sen,
    output logic                      xrst,
    output logic                      xenc,
    output logic                      xen,
    output logic                      yrst,
    output logic                      yenc,
    output logic                      yen,
    output logic                      zrst,
    output logic                      zenc,
    output logic                      zen,
    output logic                      erst,
    output logic                      correct_cnt,
    output logic                      tk1s,
    output dbg_t                      dbg
);

    localparam int BEATS = 128 / buswidth;

    state_t      state;
    logic [7:0]  beat_cnt;
    logic [5:0]  round_cnt;
    logic        done_q;
    logic        decrypt_q;
    logic [7:0]  domain_q;
    logic [5:0]  rc;
    logic [11:0] lfsr_constant;
    logic        accept;

    // Handshakes: a beat moves only in a cycle where valid and ready are both
    // high; the command port uses the same rule with cmd_ready = (state == IDLE).
    assign accept = cmd_valid && (state == S_IDLE);

    romulus_rc_lfsr u_rc_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && (cmd == CMD_TBC)),
        .step     (state == S_ROUND),
        .rc       (rc),
        .constant (lfsr_constant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            round_cnt <= '0;
            done_q    <= 1'b0;
            decrypt_q <= 1'b0;
            domain_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        domain_q  <= cmd_domain;
                        decrypt_q <= cmd_decrypt;
                        beat_cnt  <= '0;
                        round_cnt <= '0;
                        case (cmd)
                            CMD_INIT:    state <= S_INIT;
                            CMD_LDKEY:   state <= S_LDKEY;
                            CMD_LDTWEAK: state <= S_LDTW;
                            CMD_ABSORB:  state <= S_ABSORB;
                            CMD_TBC:     state <= S_ROUND;
                            CMD_INCCNT:  state <= S_INCCNT;
                            default:     done_q <= 1'b1;
                        endcase
                    end
                end
                S_INIT, S_INCCNT, S_CORRECT: begin
                    state  <= S_IDLE;
                    done_q <= 1'b1;
                end
                S_LDKEY, S_LDTW, S_ABSORB: begin
                    if ((state == S_LDKEY  && sdi_valid) ||
                        (state == S_LDTW   && pdi_valid) ||
                        (state == S_ABSORB && pdi_valid && pdo_ready)) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == 8'(BEATS - 1)) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    round_cnt <= round_cnt + 6'd1;
                    if (round_cnt == 6'(NROUNDS - 1)) begin
                        state <= S_CORRECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready   = (state == S_IDLE);
        done        = done_q;
        sdi_ready   = 1'b0;
        pdi_ready   = 1'b0;
        pdo_valid   = 1'b0;
        constant    = '0;
        decrypt     = '0;
        srst        = 1'b0;
        senc        = 1'b0;
        sen         = 1'b0;
        xrst        = 1'b0;
        xenc        = 1'b0;
        xen         = 1'b0;
        yrst        = 1'b0;
        yenc        = 1'b0;
        yen         = 1'b0;
        zrst        = 1'b0;
        zenc        = 1'b0;
        zen         = 1'b0;
        erst        = 1'b0;
        correct_cnt = 1'b0;
        tk1s        = 1'b0;
        case (state)
            S_INIT: begin
                srst = 1'b1;
                zrst = 1'b1;
                erst = 1'b1;
            end
            S_LDKEY: begin
                sdi_ready = 1'b1;
                xrst      = sdi_valid;
            end
            S_LDTW: begin
                pdi_ready = 1'b1;
                yrst      = pdi_valid;
            end
            S_ABSORB: begin
                pdo_valid = pdi_valid;
                pdi_ready = pdo_ready;
                sen       = pdi_valid && pdo_ready;
                decrypt   = {(buswidth/8){decrypt_q}};
            end
            S_ROUND: begin
                sen      = 1'b1;
                senc     = 1'b1;
                xen      = 1'b1;
                xenc     = 1'b1;
                yen      = 1'b1;
                yenc     = 1'b1;
                zen      = 1'b1;
                zenc     = 1'b1;
                constant = lfsr_constant;
            end
            S_CORRECT: begin
                xen = 1'b1;
                yen = 1'b1;
                zen = 1'b1;
            end
            S_INCCNT: begin
                zen         = 1'b1;
                correct_cnt = 1'b1;
            end
            default: ;
        endcase
    end

    assign domain = domain_q;

    always_comb begin
        dbg.state     = state;
        dbg.rc        = rc;
        dbg.round_cnt = round_cnt;
        dbg.beat_cnt  = beat_cnt;
    end

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Directed bench for romulus_tbc_sequencer: a command table plus hand-written
// multi-cycle sequences, against a 128-bit and a 32-bit instance.
module tb_romulus_tbc_sequencer;
    import romulus_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_valid_k;
    logic [2:0]  cmd;
    logic [7:0]  cmd_domain;
    logic        cmd_decrypt;
    logic        sdi_valid, pdi_valid, pdo_ready;

    logic        cmd_ready, sdi_ready, pdi_ready, pdo_valid, done;
    logic [11:0] constant;
    logic [15:0] decrypt;
    logic [7:0]  domain;
    logic        srst, senc, sen, xrst, xenc, xen, yrst, yenc, yen;
    logic        zrst, zenc, zen, erst, correct_cnt, tk1s;
    dbg_t        dbg;

    logic        cmd_ready_k, sdi_ready_k, pdi_ready_k, pdo_valid_k, done_k;
    logic [11:0] constant_k;
    logic [3:0]  decrypt_k;
    logic [7:0]  domain_k;
    logic        srst_k, senc_k, sen_k, xrst_k, xenc_k, xen_k, yrst_k, yenc_k, yen_k;
    logic        zrst_k, zenc_k, zen_k, erst_k, correct_cnt_k, tk1s_k;
    dbg_t        dbg_k;

    logic [14:0] strobes;
    assign strobes = {srst, senc, sen, xrst, xenc, xen, yrst, yenc, yen,
                      zrst, zenc, zen, erst, correct_cnt, tk1s};

    romulus_tbc_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_domain(cmd_domain), .cmd_decrypt(cmd_decrypt),
        .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
        .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
        .pdo_valid(pdo_valid), .pdo_ready(pdo_ready),
        .done(done), .constant(constant), .decrypt(decrypt), .domain(domain),
        .srst(srst), .senc(senc), .sen(sen), .xrst(xrst), .xenc(xenc), .xen(xen),
        .yrst(yrst), .yenc(yenc), .yen(yen), .zrst(zrst), .zenc(zenc), .zen(zen),
        .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s), .dbg(dbg)
    );

    romulus_tbc_sequencer #(.buswidth(32)) dut_k (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_k), .cmd_ready(cmd_ready_k),
        .cmd(cmd), .cmd_domain(cmd_domain), .cmd_decrypt(cmd_decrypt),
        .sdi_valid(sdi_valid), .sdi_ready(sdi_ready_k),
        .pdi_valid(1'b0), .pdi_ready(pdi_ready_k),
        .pdo_valid(pdo_valid_k), .pdo_ready(1'b0),
        .done(done_k), .constant(constant_k), .decrypt(decrypt_k), .domain(domain_k),
        .srst(srst_k), .senc(senc_k), .sen(sen_k), .xrst(xrst_k), .xenc(xenc_k), .xen(xen_k),
        .yrst(yrst_k), .yenc(yenc_k), .yen(yen_k), .zrst(zrst_k), .zenc(zenc_k), .zen(zen_k),
        .erst(erst_k), .correct_cnt(correct_cnt_k), .tk1s(tk1s_k), .dbg(dbg_k)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic dec);
        settle();
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd         = c;
        cmd_domain  = d;
        cmd_decrypt = dec;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid   = 1'b0;
        settle();
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 200) begin
            tick();
            settle();
            cycles++;
        end
    endtask

    typedef struct {
        logic [2:0]  c;
        logic [7:0]  dom;
        logic        dec;
        int          lat;
        logic [14:0] t1;
    } vec_t;

    localparam logic [14:0] ST_INIT   = 15'h4024;
    localparam logic [14:0] ST_INC    = 15'h000A;
    localparam logic [14:0] ST_ROUND  = 15'h36D8;
    localparam logic [14:0] ST_CORR   = 15'h0248;

    vec_t        tab[5];
    logic [11:0] ctab[7];
    int          pat[6];
    int          lat;
    logic [5:0]  mrc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{c: 3'd6, dom: 8'h11, dec: 1'b0, lat: 1,  t1: 15'h0};
        tab[1] = '{c: 3'd7, dom: 8'h4A, dec: 1'b0, lat: 1,  t1: 15'h0};
        tab[2] = '{c: 3'd0, dom: 8'h23, dec: 1'b1, lat: 2,  t1: ST_INIT};
        tab[3] = '{c: 3'd5, dom: 8'h5C, dec: 1'b1, lat: 2,  t1: ST_INC};
        tab[4] = '{c: 3'd4, dom: 8'h80, dec: 1'b0, lat: 42, t1: ST_ROUND};
        ctab = '{12'h201, 12'h203, 12'h207, 12'h20F, 12'h21F, 12'h23E, 12'h23D};
        pat  = '{1, 0, 1, 1, 0, 1};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_valid_k = 1'b0; cmd = '0; cmd_domain = '0;
        cmd_decrypt = 1'b0; sdi_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        settle();

        // reset state
        check("rst_state", 32'(dbg.state), 32'(S_IDLE));
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", 32'(strobes), 32'd0);
        check("rst_handshakes", {29'd0, sdi_ready, pdi_ready, pdo_valid}, 32'd0);
        check("rst_constant", 32'(constant), 32'd0);
        check("rst_domain", 32'(domain), 32'd0);
        check("rst_rc", 32'(dbg.rc), 32'h01);

        // command table: strobes at T+1, completion latency, domain latch
        for (int i = 0; i < 5; i++) begin
            issue(tab[i].c, tab[i].dom, tab[i].dec);
            check("tab_strobes_t1", 32'(strobes), 32'(tab[i].t1));
            wait_done(lat);
            check("tab_latency", 32'(lat), 32'(tab[i].lat));
            check("tab_domain", 32'(domain), 32'(tab[i].dom));
            check("tab_decrypt_idle", 32'(decrypt), 32'd0);
            check("tab_done_strobes", 32'(strobes), 32'd0);
            tick();
        end

        // full TBC walk: constants, strobes, correction cycle, done at T+42
        issue(CMD_TBC, 8'h00, 1'b0);
        mrc = 6'h01;
        for (int r = 1; r <= 40; r++) begin
            check("tbc_round_strobes", {16'd0, done, strobes}, {16'd0, 1'b0, ST_ROUND});
            check("tbc_round_constant", 32'(constant), {20'd0, 4'h2, 2'b00, mrc});
            if (r <= 7) check("tbc_constant_table", 32'(constant), 32'(ctab[r-1]));
            mrc = {mrc[4:0], mrc[5] ^ mrc[4] ^ 1'b1};
            tick();
            settle();
        end
        check("tbc_correct_strobes", {16'd0, done, strobes}, {16'd0, 1'b0, ST_CORR});
        check("tbc_correct_constant", 32'(constant), 32'd0);
        tick();
        settle();
        check("tbc_done_t42", {30'd0, done, cmd_ready}, 32'd3);
        tick();

        // reset in round 17 aborts with no done; next TBC restarts rc
        issue(CMD_TBC, 8'h00, 1'b0);
        repeat (16) tick();
        settle();
        check("mid_round17_constant", 32'(constant), {20'd0, 12'h200 | 12'(dbg.rc)});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("abort_state", 32'(dbg.state), 32'(S_IDLE));
        check("abort_outputs", {15'd0, done, cmd_ready, strobes}, {15'd0, 1'b0, 1'b1, 15'd0});
        check("abort_constant", 32'(constant), 32'd0);
        tick();
        settle();
        check("abort_no_done", 32'(done), 32'd0);
        issue(CMD_TBC, 8'h00, 1'b0);
        check("restart_constant", 32'(constant), 32'h201);
        check("restart_strobes", 32'(strobes), 32'(ST_ROUND));
        wait_done(lat);
        check("restart_latency", 32'(lat), 32'd42);
        tick();

        // LDKEY on the 32-bit instance with gaps in sdi_valid
        settle();
        check("k_cmd_ready", 32'(cmd_ready_k), 32'd1);
        cmd = CMD_LDKEY;
        cmd_valid_k = 1'b1;
        tick();
        cmd_valid_k = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sdi_valid = pat[i][0];
            settle();
            check("k_xrst", 32'(xrst_k), 32'(pat[i]));
            check("k_sdi_ready_done", {30'd0, sdi_ready_k, done_k}, 32'd2);
            tick();
        end
        sdi_valid = 1'b0;
        settle();
        check("k_done", {29'd0, done_k, sdi_ready_k, xrst_k}, 32'd4);
        tick();

        // ABSORB with output back-pressure, decrypt select
        issue(CMD_ABSORB, 8'h00, 1'b1);
        pdi_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pdo_ready = 1'b0;
            settle();
            check("abs_stall", {29'd0, sen, pdo_valid, pdi_ready}, 32'd2);
            check("abs_decrypt", 32'(decrypt), 32'hFFFF);
            check("abs_stall_done", 32'(done), 32'd0);
            tick();
        end
        pdo_ready = 1'b1;
        settle();
        check("abs_xfer", {29'd0, sen, pdo_valid, pdi_ready}, 32'd7);
        check("abs_senc", 32'(senc), 32'd0);
        tick();
        pdi_valid = 1'b0;
        pdo_ready = 1'b0;
        settle();
        check("abs_done", {15'd0, done, strobes}, {15'd0, 1'b1, 15'd0});
        check("abs_decrypt_after", 32'(decrypt), 32'd0);
        tick();

        // INIT then INCCNT with cmd_valid held throughout
        settle();
        cmd = CMD_INIT;
        cmd_domain = 8'h33;
        cmd_valid = 1'b1;
        tick();
        settle();
        check("b2b_init_strobes", 32'(strobes), 32'(ST_INIT));
        check("b2b_init_busy", 32'(cmd_ready), 32'd0);
        cmd = CMD_INCCNT;
        tick();
        settle();
        check("b2b_init_done", {30'd0, done, cmd_ready}, 32'd3);
        tick();
        cmd_valid = 1'b0;
        settle();
        check("b2b_inccnt_strobes", 32'(strobes), 32'(ST_INC));
        check("b2b_inccnt_nodone", 32'(done), 32'd0);
        tick();
        settle();
        check("b2b_inccnt_done", 32'(done), 32'd1);
        tick();

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/romulus_tbc_sequencer.md
Name: romulus_tbc_sequencer

Overview:
Control sequencer that drives the Romulus datapath strobes: key load, tweak load, state absorb/squeeze, TBC rounds with SKINNY round constants, key-schedule correction and counter increment. Sits directly upstream of the datapath and converts one-at-a-time commands plus pdi/sdi/pdo valid/ready handshakes into per-cycle enable, reset and select lines.

Parameters:
buswidth, 128, datapath bus width; must divide 128; BEATS = 128/buswidth.
constantwidth, 12, width of constant output; must equal 12.
NROUNDS, 40, TBC rounds per call, one round per cycle; 1..63.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd  in  3  0 INIT, 1 LDKEY, 2 LDTWEAK, 3 ABSORB, 4 TBC, 5 INCCNT, 6-7 NOP
cmd_domain  in  8  domain byte, latched on acceptance
cmd_decrypt  in  1  decrypt flag, latched on acceptance
sdi_valid / sdi_ready  in/out  1  key beat handshake
pdi_valid / pdi_ready  in/out  1  tweak or data beat handshake
pdo_valid / pdo_ready  out/in  1  output beat handshake (ABSORB only)
done  out  1  one-cycle completion pulse
constant  out  constantwidth  round constant
decrypt  out  buswidth/8  per-byte decrypt select
domain  out  8  latched domain byte
srst senc sen xrst xenc xen yrst yenc yen zrst zenc zen erst correct_cnt tk1s  out  1 each  datapath strobes

Behaviour:
- Reset: state IDLE; beat and round counters 0; rc = 6'h01; domain and decrypt latches 0; all strobes, done, pdo_valid, pdi_ready and sdi_ready 0; cmd_ready 1 from the first cycle after reset. Reset mid-command aborts immediately, with no done pulse.
- States: IDLE, INIT, LDKEY, LDTW, ABSORB, ROUND, CORRECT. A command is accepted on cmd_valid && cmd_ready (cycle T).
- Every strobe not listed for a state is 0. tk1s is 0 always (reserved).
- INIT: at T+1, srst = zrst = erst = 1. done at T+2.
- LDKEY: sdi_ready = 1. xrst = sdi_valid. Each beat transfer increments the beat counter. Leave after beat BEATS-1 transfers; done the following cycle.
- LDTW: same as LDKEY, using pdi_valid/pdi_ready and yrst.
- ABSORB: pdo_valid = pdi_valid and pdi_ready = pdo_ready (combinational). sen = pdi_valid && pdo_ready, senc = 0. decrypt = all bits set to the latched cmd_decrypt, and 0 outside ABSORB. Ends after BEATS transfers; done the next cycle.
- ROUND, cycles T+1..T+NROUNDS: sen = senc = xen = xenc = yen = yenc = zen = zenc = 1.
  - constant = {4'h2, 2'b00, rc[5:4], rc[3:0]}; 0 outside ROUND.
  - rc steps each ROUND cycle: rc <= {rc[4:0], rc[5]^rc[4]^1}. rc is reloaded to 6'h01 on TBC acceptance.
- CORRECT at T+NROUNDS+1: xen = yen = zen = 1, all enc = 0, correct_cnt = 0. IDLE with done at T+NROUNDS+2 (42 cycles for the default NROUNDS).
- INCCNT: at T+1, zen = 1, zenc = 0, correct_cnt = 1. done at T+2.
- NOP: done at T+1, with no strobes.
- domain output always shows the latch.
- done and cmd_ready are both high in the done cycle, so a back-to-back command may be accepted in that same cycle.
- Stalls: valid low or pdo_ready low holds state, counters and all strobes at 0. No timeout.

Decomposition:
- Package romulus_pkg holds:
  - command encodings and the state encoding;
  - RC_INIT = 6'h01 and the C2 nibble 4'h2;
  - a function for the rc next-state.
- One sub-module, romulus_rc_lfsr (load, step, rc, constant), for reuse by an unrolled datapath.

Test Plan:
- Reset mid-TBC at round 17: rst high 1 cycle -> next cycle IDLE, all strobes 0, no done; a new TBC then starts with constant 12'h201.
- TBC command -> constants 12'h201, 12'h203, 12'h207, 12'h20F, 12'h21F, 12'h23E, 12'h23D on rounds 1-7; 40 ROUND cycles with all enc/en high; 1 CORRECT cycle with correct_cnt = 0; done exactly 42 cycles after acceptance.
- LDKEY with buswidth = 32 and sdi_valid toggling 1,0,1,1,0,1 -> xrst high on exactly the 4 valid cycles; done one cycle after the 4th beat.
- ABSORB, cmd_decrypt = 1, buswidth = 128, pdo_ready low for 3 cycles then high -> sen 0 for 3 cycles, then 1 for 1 cycle; decrypt = 16'hFFFF during ABSORB; done next cycle.
- INIT then INCCNT back-to-back with cmd_valid held -> srst/zrst/erst pulse at T+1; INCCNT accepted in the done cycle; zen = 1, zenc = 0, correct_cnt = 1 one cycle later.
- cmd = 7 -> done at T+1, no strobe asserted; domain output equals the latched cmd_domain (e.g. 8'h4A).
